// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage PC sequencer with imem handshake, skid slot and redirect flush
module fetch_ctrl #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic            Clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr,
   output logic            misalign_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;
   logic [31:0]     skid_instr_q, skid_instr_d;
   logic            skid_valid_q, skid_valid_d;
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic [31:0]     out_instr_q, out_instr_d;
   logic            misalign_q, misalign_d;
   logic [XLEN-1:0] redirect_aligned;
   logic            slot_free;

   // The low two bits of a redirect target are dropped; the word-aligned address is fetched.
   assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

   // The output slot can take a new word if it is empty or being consumed this cycle.
   assign slot_free = !out_valid_q || !stall;

   // Next-state and datapath decisions; redirect overrides stall and ack in every state.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      skid_valid_d = skid_valid_q;
      out_valid_d  = out_valid_q && stall;
      out_pc_d     = out_pc_q;
      out_instr_d  = out_instr_q;
      misalign_d   = 1'b0;

      if (redirect) begin
         pc_d         = redirect_aligned;
         misalign_d   = |redirect_pc[1:0];
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         unique case (state_q)
            ST_FETCH: state_d = imem_ack ? ST_FETCH : ST_FLUSH;
            ST_FLUSH: state_d = ST_FLUSH;
            default:  state_d = ST_FETCH;
         endcase
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_FETCH;
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  pc_d = pc_q + XLEN'(4);
                  if (slot_free) begin
                     out_valid_d = 1'b1;
                     out_pc_d    = pc_q;
                     out_instr_d = imem_rdata;
                  end else begin
                     skid_valid_d = 1'b1;
                     skid_pc_d    = pc_q;
                     skid_instr_d = imem_rdata;
                     state_d      = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  out_valid_d  = 1'b1;
                  out_pc_d     = skid_pc_q;
                  out_instr_d  = skid_instr_q;
                  skid_valid_d = 1'b0;
                  state_d      = ST_FETCH;
               end
            end
            ST_FLUSH: begin
               // The stale response is dropped; the redirect target is fetched next.
               if (imem_ack) begin
                  state_d = ST_FETCH;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // The request address is frozen while a flushed request is still in flight.
      addr_d = (state_d == ST_FLUSH) ? addr_q : pc_d;
   end

   // FSM state register.
   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // PC, request address, skid slot and IF/ID output registers.
   always_ff @(posedge Clk) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         addr_q       <= RESET_PC;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
         skid_valid_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_pc_q     <= '0;
         out_instr_q  <= '0;
         misalign_q   <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         addr_q       <= addr_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_valid_q <= skid_valid_d;
         out_valid_q  <= out_valid_d;
         out_pc_q     <= out_pc_d;
         out_instr_q  <= out_instr_d;
         misalign_q   <= misalign_d;
      end
   end

   assign imem_req     = (state_q == ST_FETCH) || (state_q == ST_FLUSH);
   assign imem_addr    = addr_q;
   assign if_valid     = out_valid_q;
   assign if_pc        = out_pc_q;
   assign if_instr     = out_instr_q;
   assign misalign_err = misalign_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage sequencer for the pipelined core: owns the PC and drives the instruction-memory request handshake.
- Presents fetched instructions to the IF/ID boundary with valid/stall flow control.
- Handles branch/jump redirects from EX, including redirects that arrive while a memory request is still outstanding.
- Sits between the hazard/branch logic and the instruction memory; replaces the free-running PC in Fetch.

Parameters:
- XLEN, 64, width of PC and addresses
- RESET_PC, 64'h0, first fetch address after reset

Ports:
- Clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  ID cannot accept; hold if_* outputs
- redirect  in  1  EX branch/jump taken this cycle
- redirect_pc  in  XLEN  target for redirect
- imem_req  out  1  instruction-memory request valid
- imem_addr  out  XLEN  request address; stable while imem_req=1 until ack
- imem_ack  in  1  response valid, sampled only when imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_ack
- if_valid  out  1  if_pc/if_instr hold a live instruction
- if_pc  out  XLEN  PC of presented instruction
- if_instr  out  32  presented instruction
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0]!=0

Behaviour:
- Reset (sync, active-high; applies in any state, even mid-transaction):
  - state=IDLE; pc=RESET_PC; imem_req=0; imem_addr=RESET_PC.
  - if_valid=0; if_pc=0; if_instr=0; skid empty; misalign_err=0.
- States: IDLE, FETCH, HOLD, FLUSH. imem_req=1 only in FETCH and FLUSH.
- IDLE: always moves to FETCH next cycle, so the first request appears 1 cycle after reset deasserts.
- FETCH:
  - imem_addr=pc; imem_req stays high until imem_ack.
  - On ack, no redirect:
    - If output slot is free (!if_valid or !stall): load if_pc=pc, if_instr=imem_rdata, if_valid=1; pc+=4; stay in FETCH.
    - Else: write {pc, rdata} into the 1-entry skid; pc+=4; go to HOLD.
- Zero-wait memory (ack every cycle): one instruction per cycle. Latency is ack-cycle -> if_valid the next cycle.
- HOLD:
  - imem_req=0.
  - When stall=0: the output register takes the skid entry (if_valid=1), skid empties, go to FETCH.
- Output consumption: an instruction is consumed in any cycle with if_valid=1 and stall=0. The output register then clears if nothing new loads.
- Redirect (priority over stall and ack):
  - Always: if_valid=0 and skid emptied next cycle.
  - redirect_pc[1:0] are forced to 0 in pc; misalign_err=1 for the next cycle only.
  - In FETCH with ack the same cycle: data discarded; pc=redirect_pc; stay in FETCH (next request goes to the new target).
  - In FETCH without ack: pc=redirect_pc; go to FLUSH. imem_addr keeps the stale address, since it must not change mid-request.
  - In HOLD or IDLE: pc=redirect_pc; go to FETCH.
  - In FLUSH: pc=redirect_pc (latest redirect wins); remain in FLUSH.
- FLUSH:
  - imem_req=1 at the stale address.
  - On ack: data discarded, go to FETCH with imem_addr=pc.
  - A stale response never reaches if_*.
- pc arithmetic: modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- Only one memory request is ever outstanding.
- Internal registers: pc, imem_addr, state, skid {pc, instr, valid}, output registers.

Test Plan:
- Reset, zero-wait memory (ack=req), stall=0 -> req rises 1 cycle after reset release; if_pc sequence 0,4,8,12,16,20,24 on consecutive cycles; instructions match imem words 0..6.
- 3-cycle memory latency (ack on 3rd req cycle) -> imem_addr stable for 3 cycles; one instruction every 3 cycles; if_valid high 1 cycle each.
- stall=1 for 4 cycles while if_pc=8 is presented, zero-wait memory -> if_pc=8 held; word at 12 held in skid; req=0 in HOLD; after stall drops, if_pc 12 then 16 on consecutive cycles with no loss or duplication.
- Redirect to 0x100 while a request to 0x20 is pending without ack -> FLUSH; req stays at 0x20 until ack; 0x20 data never reaches if_*; next request is at 0x100; if_pc=0x100 follows.
- Redirect to 0x202 in the same cycle as ack -> misalign_err pulses 1 cycle; next request at 0x200; if_valid=0 for the cycle after the redirect.
- Reset asserted during FLUSH with outstanding request -> next cycle state IDLE, if_valid=0, req=0; fetch restarts at RESET_PC.
